// File: rtl/rf_shadow_monitor_if.sv
// rf_shadow_monitor_if: bus between the regfile write port / debug consumer
// and the shadow monitor.
//   wr_en, wr_addr, wr_data : snooped regfile write port
//   rd_addr, rd_data        : shadow readback (rd_data registered, 1-cycle latency)
//   log_valid, log_addr,
//   log_data, log_cycle     : write-log FIFO head (first-word fall-through)
//   log_pop                 : dequeue the head entry
// modport master: the side driving writes/readback/pops.
// modport slave : the monitor itself.
interface rf_shadow_monitor_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CYC_W  = 32
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              log_valid;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic [CYC_W-1:0]  log_cycle;
    logic              log_pop;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, log_pop,
        input  rd_data, log_valid, log_addr, log_data, log_cycle
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, log_pop,
        output rd_data, log_valid, log_addr, log_data, log_cycle
    );
endinterface

// File: rtl/rf_shadow_monitor.sv
// rf_shadow_monitor: architectural shadow of the regfile with registered
// readback, nonzero mask, cycle-stamped write log FIFO and an
// IDLE/RUN/DONE run controller with heartbeat.
//
// Ports:
//   clock_i          single clock, rising edge
//   reset_i          synchronous, active-high reset
//   run_i            start request, sampled in IDLE
//   bus_io           rf_shadow_monitor_if.slave (write snoop, readback, log FIFO)
//   nonzero_mask_o   bit i set when shadow[i] != 0
//   log_count_o      FIFO occupancy
//   log_overflow_o   sticky, a log entry was dropped
//   cycle_count_o    RUN cycles elapsed (saturating)
//   heartbeat_o      single-cycle pulse every HEARTBEAT RUN cycles
//   state_o          IDLE=0, RUN=1, DONE=2
//   done_o           high in DONE
//   rstatus_seen_o   sticky r30-written flag (optional feature)
//   rstatus_value_o  last r30 write data (optional feature)
//
// Optional feature macro: RF_SHADOW_RSTATUS_EN enables r30 status capture;
// when undefined the rstatus outputs are tied to 0.
module rf_shadow_monitor #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned LOG_DEPTH  = 16,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned HEARTBEAT  = 100,
    parameter int unsigned MAX_CYCLES = 2000
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       run_i,
    rf_shadow_monitor_if.slave         bus_io,
    output logic [NREG-1:0]            nonzero_mask_o,
    output logic [$clog2(LOG_DEPTH):0] log_count_o,
    output logic                       log_overflow_o,
    output logic [CYC_W-1:0]           cycle_count_o,
    output logic                       heartbeat_o,
    output logic [1:0]                 state_o,
    output logic                       done_o,
    output logic                       rstatus_seen_o,
    output logic [DATA_W-1:0]          rstatus_value_o
);

    localparam int unsigned PtrW = $clog2(LOG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = ADDR_W + DATA_W + CYC_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q;
    logic              done_q;
    logic [CYC_W-1:0]  cycle_q;
    logic              hb_q;
    logic              hb_fire;

    logic              accept;
    logic              pop_ok;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;

    logic [DATA_W-1:0] shadow_q [NREG];
    logic [NREG-1:0]   mask_q;
    logic [DATA_W-1:0] rd_q;

    logic [EntW-1:0]   fifo_q [LOG_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              ovf_q;

    // ------------------------------------------------------------------
    // Run controller
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            cycle_q <= '0;
            hb_q    <= 1'b0;
        end else begin
            hb_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (run_i) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (cycle_q != '1) begin
                        cycle_q <= cycle_q + CYC_W'(1);
                    end
                    hb_q <= hb_fire;
                    if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Heartbeat down-counter: zero on the first RUN cycle, so cycle 0 fires.
    if (HEARTBEAT != 0) begin : g_hb
        localparam int unsigned HbW = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
        logic [HbW-1:0] hb_cnt_q;

        assign hb_fire = (state_q == StRun) && (hb_cnt_q == '0);

        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                hb_cnt_q <= '0;
            end else if (state_q == StRun) begin
                if (hb_cnt_q == '0) begin
                    hb_cnt_q <= HbW'(HEARTBEAT - 1);
                end else begin
                    hb_cnt_q <= hb_cnt_q - HbW'(1);
                end
            end
        end
    end else begin : g_no_hb
        assign hb_fire = 1'b0;
    end

    // ------------------------------------------------------------------
    // Shadow copy, mask and readback
    // ------------------------------------------------------------------
    assign accept = (state_q == StRun) && bus_io.wr_en && (bus_io.wr_addr != '0);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(NREG); i++) begin
                shadow_q[i] <= '0;
            end
            mask_q <= '0;
            rd_q   <= '0;
        end else begin
            if (accept) begin
                shadow_q[bus_io.wr_addr] <= bus_io.wr_data;
                mask_q[bus_io.wr_addr]   <= |bus_io.wr_data;
            end
            // Write-first: a same-cycle write to the read address bypasses.
            if (accept && (bus_io.wr_addr == bus_io.rd_addr)) begin
                rd_q <= bus_io.wr_data;
            end else begin
                rd_q <= shadow_q[bus_io.rd_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-log FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(LOG_DEPTH));
    assign pop_ok     = bus_io.log_pop && !fifo_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = accept && (!fifo_full || pop_ok);

    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= {bus_io.wr_addr, bus_io.wr_data, cycle_q};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (accept && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional r30 status capture
    // ------------------------------------------------------------------
`ifdef RF_SHADOW_RSTATUS_EN
    localparam logic [ADDR_W-1:0] RstatusAddr = ADDR_W'(30);
    logic              rs_seen_q;
    logic [DATA_W-1:0] rs_value_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rs_seen_q  <= 1'b0;
            rs_value_q <= '0;
        end else if (accept && (bus_io.wr_addr == RstatusAddr)) begin
            rs_seen_q  <= 1'b1;
            rs_value_q <= bus_io.wr_data;
        end
    end

    assign rstatus_seen_o  = rs_seen_q;
    assign rstatus_value_o = rs_value_q;
`else
    assign rstatus_seen_o  = 1'b0;
    assign rstatus_value_o = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_io.rd_data   = rd_q;
    assign bus_io.log_valid = !fifo_empty;
    assign {bus_io.log_addr, bus_io.log_data, bus_io.log_cycle} =
        fifo_empty ? '0 : fifo_q[rd_ptr_q];

    assign nonzero_mask_o = mask_q;
    assign log_count_o    = count_q;
    assign log_overflow_o = ovf_q;
    assign cycle_count_o  = cycle_q;
    assign heartbeat_o    = hb_q;
    assign state_o        = state_q;
    assign done_o         = done_q;

endmodule
